fetch_sequencer: RTL
====================

# fetch_sequencer

Multi-cycle instruction-fetch controller that owns the program counter and sequences it against an instruction memory with variable response latency. It issues one fetch per instruction, presents the fetched word to the decode/execute stage with a valid/ready handshake, and advances the PC sequentially or to a branch/jump target. It replaces free-running PC advance wherever the instruction memory is not single-cycle.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- br_taken  in  1  redirect request from execute (B, JAL, JALR); sampled only on the retire handshake.
- ALU_imm  in  32  redirect target; valid with br_taken.
- halt_req  in  1  stop fetching after the current instruction (ECALL/EBREAK); sampled only on the retire handshake.
- imem_req  out  1  fetch request strobe, high for exactly one cycle per fetch.
- imem_addr  out  32  fetch address, equals PC while imem_req=1, otherwise holds PC.
- imem_valid  in  1  memory response valid, one-cycle pulse.
- imem_rdata  in  32  instruction word, valid with imem_valid.
- instr_valid  out  1  fetched instruction available.
- instr  out  32  fetched instruction word.
- instr_pc  out  32  address of instr.
- instr_ready  in  1  downstream retires instr this cycle.
- PC  out  32  current fetch PC.
- halted  out  1  sequencer stopped; sticky until reset.
- misalign  out  1  halted because of a misaligned redirect target; sticky until reset.

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT.
- Reset: state=IDLE, PC=RESET_VEC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, misalign=0. Reset overrides every other input in any state, including an outstanding fetch. A response arriving after reset is ignored because the sequencer is not in WAIT.
- IDLE: go to REQ unconditionally.
- REQ: imem_req=1, imem_addr=PC. Go to WAIT. imem_valid is ignored in this state.
- WAIT: imem_req=0. On imem_valid, latch instr=imem_rdata and instr_pc=PC, then go to HOLD. With no response, wait indefinitely; there is no timeout.
- HOLD: instr_valid=1, with instr and instr_pc stable. The retire handshake is instr_valid & instr_ready. On retire, with priority in this order:
  - halt_req: go to HALT, set halted=1, PC unchanged.
  - br_taken with ALU_imm[1:0]≠0: go to HALT, set halted=1 and misalign=1, PC unchanged.
  - br_taken: PC<=ALU_imm, go to REQ.
  - otherwise: PC<=PC+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), go to REQ.
- Without retire, HOLD persists; br_taken and halt_req are ignored.
- HALT: terminal state. imem_req=0, instr_valid=0. Exit only by reset.
- imem_valid outside WAIT is discarded, and no state changes.
- instr_valid is 1 only in HOLD.

## Timing
- Cycle 0 is the first cycle with reset=0 (IDLE). Cycle 1: REQ, imem_req=1. Earliest imem_valid is cycle 2, giving instr_valid in cycle 3.
- Minimum of 3 cycles per instruction (REQ→WAIT→HOLD) with zero-wait memory and instr_ready held high.
- The PC update, and the registered next state, take effect the cycle after the retire handshake. imem_req for the new PC asserts in that cycle.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- fetch_pkg holds:
  - the state enum fetch_state_t (IDLE, REQ, WAIT, HOLD, HALT);
  - the localparams INSTR_BYTES=4 and XLEN=32.
- Sub-module pc_next_calc (combinational). Inputs: PC, br_taken, ALU_imm, halt_req. Outputs: next PC, a misaligned flag, and a stop flag. The FSM and all registers live in fetch_sequencer.

## Test plan
- Reset, then a memory with 0-cycle wait, instr_ready=1 → imem_addr sequence 0x0, 0x4, 0x8, with one imem_req per 3 cycles. First instr_valid occurs at cycle 3.
- Memory returning valid after 5 WAIT cycles, with instr_ready low for 4 cycles in HOLD → instr and instr_pc stable throughout, no extra imem_req, PC advances exactly once.
- Retire at PC=0x10 with br_taken=1, ALU_imm=0x100 → next imem_addr=0x100, instr_pc=0x100. Also: br_taken pulsed during WAIT or during HOLD without ready → no redirect.
- Retire with br_taken=1, ALU_imm=0x102 → halted=1, misalign=1, PC stays 0x10, imem_req stays 0 for 20 cycles. Reset then clears both flags and restarts at RESET_VEC.
- Retire with halt_req=1 and br_taken=1 together → HALT with misalign=0 (halt has priority). Separately, RESET_VEC=0xFFFF_FFFC: the second fetch address is 0x0.
- Reset asserted in WAIT, then a late imem_valid pulse in IDLE → response discarded, instr_valid stays 0, first fetch is RESET_VEC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int XLEN        = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - retire-time PC selection: halt, misaligned redirect, redirect, or sequential
module pc_next_calc
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] alu_imm,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc_next,
  output logic            misaligned,
  output logic            stop
);

  logic tgt_unaligned;

  always_comb begin
    tgt_unaligned = (alu_imm[1:0] != 2'b00);
    // halt_req outranks the redirect, so a simultaneous bad target is not flagged
    misaligned    = !halt_req && br_taken && tgt_unaligned;
    stop          = halt_req || misaligned;
    if (stop) begin
      pc_next = pc;
    end else if (br_taken) begin
      pc_next = alu_imm;
    end else begin
      pc_next = pc + XLEN'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner sequencing one fetch per instruction against variable-latency imem
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [31:0] ALU_imm,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] PC,
  output logic        halted,
  output logic        misalign
);

  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic halted_q, halted_d;
  logic misalign_q, misalign_d;

  logic [XLEN-1:0] pc_next;
  logic            pc_misaligned;
  logic            pc_stop;

  pc_next_calc u_pc_next_calc (
    .pc         (pc_q),
    .br_taken   (br_taken),
    .alu_imm    (ALU_imm),
    .halt_req   (halt_req),
    .pc_next    (pc_next),
    .misaligned (pc_misaligned),
    .stop       (pc_stop)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    halted_d   = halted_q;
    misalign_d = misalign_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_valid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // instr_valid is implied by HOLD, so instr_ready alone completes the retire
        if (instr_ready) begin
          if (pc_stop) begin
            state_d    = HALT;
            halted_d   = 1'b1;
            misalign_d = pc_misaligned;
          end else begin
            pc_d    = pc_next;
            state_d = REQ;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VEC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign PC          = pc_q;
  assign halted      = halted_q;
  assign misalign    = misalign_q;

endmodule
